// File: rtl/ms_count_display.sv
// Millisecond-count display driver: sequential double-dabble binary-to-BCD
// conversion feeding six registered seven-segment digits (SSSmmm).
module ms_count_display #(
    parameter int unsigned IN_W        = 20,
    parameter int unsigned N_DIGITS    = 7,
    parameter bit          SEG_ACT_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [IN_W-1:0]         ms_count,
    input  logic                    conv_start,
    output logic                    busy,
    output logic                    done,
    output logic [4*N_DIGITS-1:0]   bcd,
    output logic                    overflow,
    output logic [6:0]              hex0,
    output logic [6:0]              hex1,
    output logic [6:0]              hex2,
    output logic [6:0]              hex3,
    output logic [6:0]              hex4,
    output logic [6:0]              hex5
);

    localparam int unsigned BCD_W  = 4 * N_DIGITS;
    localparam int unsigned CNT_W  = $clog2(IN_W + 1);
    localparam int unsigned OVF_LO = 24;
    localparam logic [6:0]  SEG_ZERO = 7'b1000000;
    localparam logic [6:0]  SEG_DASH = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               load;
    logic               shift_en;
    logic               finish;
    logic [IN_W-1:0]    bin;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_c;
    logic [6:0]         hex_q [6];

    // Patterns are stored active-low; flip for common-cathode boards.
    function automatic logic [6:0] polar(input logic [6:0] p);
        return SEG_ACT_LOW ? p : ~p;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next state and per-cycle datapath strobes.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (conv_start) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt == CNT_W'(1)) next_state = DONE;
            end
            DONE: begin
                finish     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Add-3 correction on every digit that would overflow past 9 after the shift.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    assign ovf_c = |scratch[BCD_W-1:OVF_LO];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin      <= '0;
            scratch  <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < 6; i++) hex_q[i] <= polar(SEG_ZERO);
        end else begin
            busy <= (state != IDLE);
            done <= finish;
            if (load) begin
                bin     <= ms_count;
                scratch <= '0;
                cnt     <= CNT_W'(IN_W);
            end else if (shift_en) begin
                scratch <= {adj[BCD_W-2:0], bin[IN_W-1]};
                bin     <= {bin[IN_W-2:0], 1'b0};
                cnt     <= cnt - CNT_W'(1);
            end
            if (finish) begin
                bcd      <= scratch;
                overflow <= ovf_c;
                for (int i = 0; i < 6; i++)
                    hex_q[i] <= polar(ovf_c ? SEG_DASH : seg_of(scratch[4*i +: 4]));
            end
        end
    end

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];

endmodule

// File: tb/tb_ms_count_display.sv
// Self-checking bench for ms_count_display: table vectors, random values
// against a decimal-arithmetic model, and timing/hazard/reset sequences.
module tb_ms_count_display;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        conv_start = 1'b0;
    logic [19:0] ms_count = '0;
    logic        busy, done, overflow;
    logic [27:0] bcd;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [6:0]  hex_all [0:5];
    logic [6:0]  segtab [0:9];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ms_count_display dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ms_count   (ms_count),
        .conv_start (conv_start),
        .busy       (busy),
        .done       (done),
        .bcd        (bcd),
        .overflow   (overflow),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .hex4       (hex4),
        .hex5       (hex5)
    );

    assign hex_all[0] = hex0;
    assign hex_all[1] = hex1;
    assign hex_all[2] = hex2;
    assign hex_all[3] = hex3;
    assign hex_all[4] = hex4;
    assign hex_all[5] = hex5;

    typedef struct {
        logic [19:0] val;
        logic [27:0] exp_bcd;
        logic        exp_ovf;
        logic [6:0]  exp_hex0;
        logic [6:0]  exp_hex4;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: repeated division by ten.
    function automatic logic [27:0] to_bcd(input int unsigned v);
        logic [27:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 7; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] exp_hex(input int unsigned v, input int idx);
        logic [27:0] b;
        logic [3:0]  d;
        if (v > 999999) return 7'b0111111;
        b = to_bcd(v);
        d = b[4*idx +: 4];
        return segtab[d];
    endfunction

    task automatic check_result(input string tag, input int unsigned v);
        chk({tag, "_bcd"}, 32'(bcd), 32'(to_bcd(v)));
        chk({tag, "_ovf"}, 32'(overflow), 32'(v > 999999));
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_hex%0d", tag, i), 32'(hex_all[i]), 32'(exp_hex(v, i)));
    endtask

    // One conversion from a conv_start pulse; optionally with in-flight hazards.
    task automatic run_conv(input logic [19:0] v, input bit hazard, input string tag,
                            output int done_at, output int ndone);
        ms_count   = v;
        conv_start = 1'b1;
        tick;
        conv_start = 1'b0;
        done_at = -1;
        ndone   = 0;
        for (int k = 1; k <= 30; k++) begin
            if (hazard && k == 3) ms_count = '0;
            if (hazard && k == 5) conv_start = 1'b1;
            if (hazard && k == 6) conv_start = 1'b0;
            tick;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
            if (k <= 22) chk({tag, "_busy"}, 32'(busy), 32'(k <= 21));
            if (k == 21) check_result(tag, int'(v));
        end
        chk({tag, "_done_cycle"}, 32'(done_at), 32'd21);
        chk({tag, "_done_count"}, 32'(ndone), 32'd1);
        chk({tag, "_bcd_hold"}, 32'(bcd), 32'(to_bcd(int'(v))));
    endtask

    initial begin
        int da, nd;
        int dpos [$];
        logic [19:0] rv;

        segtab[0] = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
        segtab[3] = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
        segtab[6] = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
        segtab[9] = 7'b0010000;

        vecs[0] = '{20'd12345,   28'h0012345, 1'b0, 7'b0010010, 7'b1111001};
        vecs[1] = '{20'd999999,  28'h0999999, 1'b0, 7'b0010000, 7'b0010000};
        vecs[2] = '{20'd1000000, 28'h1000000, 1'b1, 7'b0111111, 7'b0111111};
        vecs[3] = '{20'hFFFFF,   28'h1048575, 1'b1, 7'b0111111, 7'b0111111};
        vecs[4] = '{20'd0,       28'h0000000, 1'b0, 7'b1000000, 7'b1000000};
        vecs[5] = '{20'd7,       28'h0000007, 1'b0, 7'b1111000, 7'b1000000};

        // Reset state
        reset_n = 1'b0;
        repeat (2) tick;
        reset_n = 1'b1;
        tick;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 6; i++)
            chk($sformatf("rst_hex%0d", i), 32'(hex_all[i]), 32'(7'b1000000));

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            run_conv(vecs[i].val, 1'b0, $sformatf("vec%0d", i), da, nd);
            chk($sformatf("vec%0d_tbl_bcd", i), 32'(bcd), 32'(vecs[i].exp_bcd));
            chk($sformatf("vec%0d_tbl_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_tbl_hex0", i), 32'(hex0), 32'(vecs[i].exp_hex0));
            chk($sformatf("vec%0d_tbl_hex4", i), 32'(hex4), 32'(vecs[i].exp_hex4));
        end

        // Input change and ignored start during a conversion
        run_conv(20'd12345, 1'b1, "hazard", da, nd);
        chk("hazard_bcd_final", 32'(bcd), 32'h0012345);

        // Random values against the model
        for (int n = 0; n < 25; n++) begin
            rv = 20'($urandom_range(0, 20'hFFFFF));
            run_conv(rv, 1'b0, $sformatf("rand%0d", n), da, nd);
        end

        // conv_start held high: reconversion every 22 cycles
        ms_count   = 20'd42;
        conv_start = 1'b1;
        tick;
        for (int k = 1; k <= 50; k++) begin
            tick;
            if (done) dpos.push_back(k);
        end
        conv_start = 1'b0;
        chk("held_done_count", 32'(dpos.size()), 32'd2);
        if (dpos.size() >= 2) begin
            chk("held_done_first", 32'(dpos[0]), 32'd21);
            chk("held_done_second", 32'(dpos[1]), 32'd43);
        end
        chk("held_bcd", 32'(bcd), 32'h0000042);
        repeat (25) tick;

        // Reset mid-conversion and recovery
        run_conv(20'd4321, 1'b0, "pre_rst", da, nd);
        ms_count   = 20'd555;
        conv_start = 1'b1;
        tick;
        conv_start = 1'b0;
        repeat (10) tick;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_bcd", 32'(bcd), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        chk("midrst_hex0", 32'(hex0), 32'(7'b1000000));
        nd = 0;
        for (int k = 0; k < 25; k++) begin
            if (k == 2) reset_n = 1'b1;
            tick;
            if (done) nd++;
        end
        chk("midrst_no_done", 32'(nd), 32'd0);
        chk("midrst_bcd_after", 32'(bcd), 32'd0);
        run_conv(20'd7, 1'b0, "recover", da, nd);
        chk("recover_bcd7", 32'(bcd), 32'h0000007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
